// File: rtl/seq_shifter_pkg.sv
// Shared mode and FSM encodings for the multi-cycle shifter/rotator.
// The control unit imports the same mode constants.
package seq_shifter_pkg;

  typedef enum logic [2:0] {
    MODE_LSL  = 3'b000,
    MODE_LSR  = 3'b001,
    MODE_ASR  = 3'b010,
    MODE_ROL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_RCL  = 3'b101,
    MODE_RCR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Single-bit shift/rotate step: one position of movement for every mode.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_e              mode,
  input  logic [WIDTH-1:0]   y,
  input  logic               c,
  output logic [WIDTH-1:0]   y_next,
  output logic               c_next
);

  // One-position move selected by mode; reserved mode holds its operand.
  always_comb begin
    y_next = y;
    c_next = c;
    case (mode)
      MODE_LSL: begin
        y_next = {y[WIDTH-2:0], 1'b0};
        c_next = y[WIDTH-1];
      end
      MODE_LSR: begin
        y_next = {1'b0, y[WIDTH-1:1]};
        c_next = y[0];
      end
      MODE_ASR: begin
        y_next = {y[WIDTH-1], y[WIDTH-1:1]};
        c_next = y[0];
      end
      MODE_ROL: begin
        y_next = {y[WIDTH-2:0], y[WIDTH-1]};
        c_next = y[WIDTH-1];
      end
      MODE_ROR: begin
        y_next = {y[0], y[WIDTH-1:1]};
        c_next = y[0];
      end
      MODE_RCL: begin
        y_next = {y[WIDTH-2:0], c};
        c_next = y[WIDTH-1];
      end
      MODE_RCR: begin
        y_next = {c, y[WIDTH-1:1]};
        c_next = y[0];
      end
      default: begin
        y_next = y;
        c_next = c;
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: loads on start, moves one bit per clock,
// then pulses done with the registered result, carry and zero flag.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] a,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             z
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_r, state_nx_s;
  mode_e            mode_r, mode_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic [WIDTH-1:0] y_r, y_nx_s, step_y_s;
  logic             c_r, c_nx_s, step_c_s;
  logic             busy_r, done_r;
  logic [AMT_W-1:0] amt_clamp_s;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .mode   (mode_r),
    .y      (y_r),
    .c      (c_r),
    .y_next (step_y_s),
    .c_next (step_c_s)
  );

  // Counts above WIDTH are pointless and are limited to WIDTH.
  always_comb begin
    amt_clamp_s = amt;
    if (amt > AMT_W'(WIDTH)) begin
      amt_clamp_s = AMT_W'(WIDTH);
    end else begin
      amt_clamp_s = amt;
    end
  end

  // Next-state and datapath selection for load, step and completion.
  always_comb begin
    state_nx_s = state_r;
    mode_nx_s  = mode_r;
    cnt_nx_s   = cnt_r;
    y_nx_s     = y_r;
    c_nx_s     = c_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          y_nx_s    = a;
          c_nx_s    = cin;
          mode_nx_s = mode_e'(mode);
          if (mode_e'(mode) == MODE_RSVD) begin
            cnt_nx_s = {CNT_W{1'b0}};
          end else begin
            cnt_nx_s = CNT_W'(amt_clamp_s);
          end
          if (cnt_nx_s == {CNT_W{1'b0}}) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_SHIFT;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        y_nx_s   = step_y_s;
        c_nx_s   = step_c_s;
        cnt_nx_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and status registers; busy/done follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      mode_r  <= MODE_LSL;
      cnt_r   <= {CNT_W{1'b0}};
      y_r     <= {WIDTH{1'b0}};
      c_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      mode_r  <= mode_nx_s;
      cnt_r   <= cnt_nx_s;
      y_r     <= y_nx_s;
      c_r     <= c_nx_s;
      busy_r  <= (state_nx_s != ST_IDLE);
      done_r  <= (state_nx_s == ST_DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign y    = y_r;
  assign c    = c_r;
  assign z    = (y_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter (WIDTH=8) with hand-computed results.
module tb_seq_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] mode;
  logic [3:0] amt;
  logic [7:0] a;
  logic       cin;
  logic       busy, done, c, z;
  logic [7:0] y;

  int tests  = 0;
  int failed = 0;

  seq_shifter #(.WIDTH(8), .AMT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .amt(amt),
    .a(a), .cin(cin), .busy(busy), .done(done), .y(y), .c(c), .z(z)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for done, check latency, busy window, results, and stability.
  task automatic run_op(input string tag, input logic [2:0] m, input logic [3:0] am,
                        input logic [7:0] av, input logic ci, input int exp_lat,
                        input logic [7:0] ey, input logic ec);
    int lat;
    logic busy_ok;
    @(negedge clk);
    mode = m; amt = am; a = av; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_busy_win"}, {31'd0, busy_ok & busy}, 32'd1);
    check_val({tag, "_y"}, {24'd0, y}, {24'd0, ey});
    check_val({tag, "_c"}, {31'd0, c}, {31'd0, ec});
    check_val({tag, "_z"}, {31'd0, z}, {31'd0, (ey == 8'h00)});
    @(negedge clk);
    check_val({tag, "_post_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_post_done"}, {31'd0, done}, 32'd0);
    check_val({tag, "_post_y"}, {24'd0, y}, {24'd0, ey});
  endtask

  initial begin
    int lat;
    int done_seen;
    rst = 1'b1; start = 1'b0; mode = 3'd0; amt = 4'd0; a = 8'h00; cin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_val("rst_y", {24'd0, y}, 32'd0);
    check_val("rst_c", {31'd0, c}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_z", {31'd0, z}, 32'd1);

    run_op("lsl",   3'b000, 4'd1,  8'h81, 1'b0, 2, 8'h02, 1'b1);
    run_op("asr",   3'b010, 4'd3,  8'h90, 1'b0, 4, 8'hF2, 1'b0);
    run_op("rcl",   3'b101, 4'd2,  8'h80, 1'b0, 3, 8'h01, 1'b0);
    run_op("ror",   3'b100, 4'd1,  8'h01, 1'b0, 2, 8'h80, 1'b1);
    run_op("rol",   3'b011, 4'd1,  8'h81, 1'b0, 2, 8'h03, 1'b1);
    run_op("lsr",   3'b001, 4'd2,  8'h03, 1'b0, 3, 8'h00, 1'b1);
    run_op("rcr",   3'b110, 4'd1,  8'h01, 1'b1, 2, 8'h80, 1'b1);
    run_op("amt0",  3'b000, 4'd0,  8'h5A, 1'b1, 1, 8'h5A, 1'b1);
    run_op("rsvd",  3'b111, 4'd5,  8'h5A, 1'b1, 1, 8'h5A, 1'b1);
    run_op("clamp", 3'b001, 4'd12, 8'hFF, 1'b0, 9, 8'h00, 1'b1);
    run_op("rol8",  3'b011, 4'd8,  8'hA5, 1'b0, 9, 8'hA5, 1'b1);

    // Start at t+2 of a 4-step LSL must be ignored; start during DONE too.
    @(negedge clk);
    mode = 3'b000; amt = 4'd4; a = 8'h1F; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    mode = 3'b001; amt = 4'd1; a = 8'hAA; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val("ign_lat", lat, 5);
    check_val("ign_y", {24'd0, y}, 32'h0000_00F0);
    check_val("ign_c", {31'd0, c}, 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("ign_done_busy", {31'd0, busy}, 32'd0);
    check_val("ign_done_y", {24'd0, y}, 32'h0000_00F0);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    mode = 3'b010; amt = 4'd3; a = 8'h90; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_y", {24'd0, y}, 32'd0);
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_done", {31'd0, done}, 32'd0);
    check_val("abort_z", {31'd0, z}, 32'd1);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check_val("abort_quiet", done_seen, 0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    mode = 3'b000; amt = 4'd1; a = 8'h81; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check_val("rst_start_busy", {31'd0, busy}, 32'd0);
    check_val("rst_start_y", {24'd0, y}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised multi-cycle shifter/rotator for the datapath, succeeding the 8-bit single-step combinational shifter. It accepts an operand, mode and shift amount on a start pulse. It shifts one bit position per clock and reports the result, carry and zero flag with a done pulse. It sits beside the ALU and is driven by the control unit for multi-bit shift/rotate instructions.

## Interface
- WIDTH, 8: operand/result width; must be ≥ 2.
- AMT_W, 4: width of the shift-amount port; must be ≥ clog2(WIDTH+1).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  3  operation select, sampled with start.
- amt  in  AMT_W  shift count, sampled with start.
- a  in  WIDTH  operand, sampled with start.
- cin  in  1  initial carry, sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the result is valid.
- y  out  WIDTH  registered result; holds until the next accepted start.
- c  out  1  registered carry-out / last bit shifted out.
- z  out  1  high when y == 0.

## Operation
- Modes:
  - 000 LSL: lsb←0, c←msb.
  - 001 LSR: msb←0, c←lsb.
  - 010 ASR: msb←msb, c←lsb.
  - 011 ROL: lsb←msb, c←msb.
  - 100 ROR: msb←lsb, c←lsb.
  - 101 RCL: lsb←c, c←msb.
  - 110 RCR: msb←c, c←lsb.
  - 111 reserved: treated as a count of 0 (pass-through).
- Start (in IDLE): y←a, c←cin, count←min(amt, WIDTH), mode latched.
  - amt greater than WIDTH is clamped to WIDTH in every mode.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE→SHIFT on start with count > 0.
  - IDLE→DONE on start with count = 0, or with mode 111.
  - SHIFT: one step per cycle and count decrements; when count reaches 0, go to DONE.
  - DONE→IDLE unconditionally after one cycle.
- start outside IDLE is ignored, including start during DONE.
- z is combinational from the y register.

## Timing
- Reset values: state IDLE, y = 0, c = 0, busy = 0, done = 0, z = 1.
- With start at edge t and count N:
  - For N > 0, busy = 1 in cycles t+1 … t+N+1.
  - done = 1 in cycle t+N+1 only; when N = 0, done is high in cycle t+1.
  - y, c and z are final when done is high and stay stable afterwards.
- busy is high during SHIFT and DONE, and low in IDLE.
- Back-to-back operation: the earliest next start is the cycle after done. Minimum throughput is N+2 cycles per operation.
- rst asserted mid-operation aborts the operation: next cycle is the reset state, with no done pulse.
- rst and start in the same cycle: rst wins.

## Structure
- Shared package/header holds the mode encodings (MODE_LSL … MODE_RCR, MODE_RSVD) and the FSM state encodings; the control unit uses the same mode constants.
- One combinational sub-module, shift_step: inputs (mode, y, c), outputs (y_next, c_next) for a single-bit step, parametrised by WIDTH.
- Top level holds the FSM, the down-counter, the clamp logic and the output registers.

## Test plan
Assumes WIDTH = 8 and start at edge t.
- LSL, a = 0x81, amt = 1, cin = 0 -> done at t+2, y = 0x02, c = 1, z = 0.
- ASR, a = 0x90, amt = 3 -> done at t+4, y = 0xF2, c = 0; busy high t+1..t+4.
- RCL, a = 0x80, cin = 0, amt = 2 -> y = 0x01, c = 0; ROR, a = 0x01, amt = 1 -> y = 0x80, c = 1.
- amt = 0, a = 0x5A, cin = 1, any mode -> done at t+1, y = 0x5A, c = 1. Mode 111 with amt = 5 gives the same result.
- LSR, a = 0xFF, amt = 12 -> clamped to 8: done at t+9, y = 0x00, c = 1, z = 1.
- Control and reset checks:
  - A second start at t+2 during a 4-step shift is ignored, and the result equals the single-operation result.
  - rst at t+2 gives y = 0, busy = 0 at t+3 and no done pulse.
